dht11_emulator: RTL and testbench

- Synthesizable DHT11 device model: the responder end of the single-wire DHT11 protocol, mirroring the host-side reader `dht11_sensor`.
- Detects the host start pulse, then drives the response preamble, 40 data bits and the end pulse on the bus.
- Lets `fsm_fan_control` and `lcd_display` be exercised on the FPGA and in simulation without a physical sensor.
- Temperature and humidity come from switches or test registers.

---
 rtl/dht11_emulator.sv | 195 +++++++++++++++++++
 tb/tb_dht11_emulator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_emulator.sv
// dht11_emulator: the sensor end of the DHT11 single-wire protocol.
// It waits for a long host low pulse, then answers with the response
// preamble, 40 data bits (humidity, 0, temperature, 0, checksum) and an
// end pulse, driving the open-drain bus through dht_drive_low.
module dht11_emulator #(
  parameter int CLKS_PER_US    = 50,
  parameter int T_START_MIN_US = 18000,
  parameter int T_WAIT_US      = 30,
  parameter int T_RESP_LOW_US  = 80,
  parameter int T_RESP_HIGH_US = 80,
  parameter int T_BIT_LOW_US   = 50,
  parameter int T_ZERO_HIGH_US = 26,
  parameter int T_ONE_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht_in,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  output logic       dht_drive_low,
  output logic       busy,
  output logic       frame_done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int START_CYC     = T_START_MIN_US * CLKS_PER_US;
  localparam int WAIT_CYC      = T_WAIT_US * CLKS_PER_US;
  localparam int RESP_LOW_CYC  = T_RESP_LOW_US * CLKS_PER_US;
  localparam int RESP_HIGH_CYC = T_RESP_HIGH_US * CLKS_PER_US;
  localparam int BIT_LOW_CYC   = T_BIT_LOW_US * CLKS_PER_US;
  localparam int ZERO_CYC      = T_ZERO_HIGH_US * CLKS_PER_US;
  localparam int ONE_CYC       = T_ONE_HIGH_US * CLKS_PER_US;

  // One counter serves both as the host-low measurement and the phase timer,
  // so it must be wide enough for the longest of them.
  localparam int MAX_CYC = max2(START_CYC,
                                max2(max2(WAIT_CYC, RESP_LOW_CYC),
                                     max2(max2(RESP_HIGH_CYC, BIT_LOW_CYC),
                                          max2(ZERO_CYC, ONE_CYC))));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] START_LIM      = CNT_W'(START_CYC);
  localparam logic [CNT_W-1:0] WAIT_LAST      = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LOW_LAST  = CNT_W'(RESP_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_HIGH_LAST = CNT_W'(RESP_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(BIT_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] ZERO_LAST      = CNT_W'(ZERO_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_LAST       = CNT_W'(ONE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } state_t;

  state_t            state;
  logic [1:0]        sync_q;
  logic              bus_level;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  phase_last;
  logic              phase_end;
  logic [5:0]        bit_idx;
  logic [39:0]       frame_bits;
  logic [7:0]        checksum;

  assign bus_level = sync_q[1];
  assign checksum  = humidity + temperature;
  assign phase_end = (cnt == phase_last);

  // Two-flop synchronizer for the bus; it resets to the idle (high) level so
  // leaving reset never looks like the start of a host pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], dht_in};
    end
  end

  // Last count value of the current timed phase; a bit's released time
  // depends on the value of the bit being sent.
  always_comb begin
    phase_last = '0;
    case (state)
      WAIT:      phase_last = WAIT_LAST;
      RESP_LOW:  phase_last = RESP_LOW_LAST;
      RESP_HIGH: phase_last = RESP_HIGH_LAST;
      BIT_LOW:   phase_last = BIT_LOW_LAST;
      BIT_HIGH:  phase_last = frame_bits[bit_idx] ? ONE_LAST : ZERO_LAST;
      END_LOW:   phase_last = BIT_LOW_LAST;
      default:   phase_last = '0;
    endcase
  end

  // Protocol sequencer; outputs are updated on the same edge as the state so
  // the bus drive switches cleanly at every phase boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      frame_bits    <= '0;
      dht_drive_low <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus_level) begin
            state <= HOST_LOW;
            cnt   <= '0;
          end
        end
        HOST_LOW: begin
          if (!bus_level) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
          end else if (cnt >= START_LIM) begin
            frame_bits <= {humidity, 8'h00, temperature, 8'h00, checksum};
            busy       <= 1'b1;
            state      <= WAIT;
            cnt        <= '0;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (phase_end) begin
            state         <= RESP_LOW;
            cnt           <= '0;
            dht_drive_low <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        RESP_LOW: begin
          if (phase_end) begin
            state         <= RESP_HIGH;
            cnt           <= '0;
            dht_drive_low <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        RESP_HIGH: begin
          if (phase_end) begin
            state         <= BIT_LOW;
            cnt           <= '0;
            bit_idx       <= 6'd39;
            dht_drive_low <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        BIT_LOW: begin
          if (phase_end) begin
            state         <= BIT_HIGH;
            cnt           <= '0;
            dht_drive_low <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        BIT_HIGH: begin
          if (phase_end) begin
            cnt           <= '0;
            dht_drive_low <= 1'b1;
            if (bit_idx == 6'd0) begin
              state <= END_LOW;
            end else begin
              bit_idx <= bit_idx - 6'd1;
              state   <= BIT_LOW;
            end
          end else cnt <= cnt + 1'b1;
        end
        END_LOW: begin
          if (phase_end) begin
            state         <= IDLE;
            cnt           <= '0;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state         <= IDLE;
          cnt           <= '0;
          dht_drive_low <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_emulator.sv
// tb_dht11_emulator: plays the host side of the DHT11 bus, predicts each
// frame from humidity/temperature and decodes the emulator's pulse train.
module tb_dht11_emulator;

  localparam int T_START   = 100;
  localparam int T_WAIT    = 30;
  localparam int T_RLOW    = 80;
  localparam int T_RHIGH   = 80;
  localparam int T_BLOW    = 50;
  localparam int T_ZERO    = 26;
  localparam int T_ONE     = 70;
  localparam int FRAME_MAX = 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       host_low = 1'b0;
  logic [7:0] temperature = 8'd0;
  logic [7:0] humidity = 8'd0;
  logic       dht_in;
  logic       dht_drive_low;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drive_rises = 0;
  int busy_rises = 0;
  int wait_len = 0;
  int mon_low_q[$];
  int mon_rel_q[$];
  logic [39:0] exp_q[$];

  // Open-drain bus with pull-up: low if either side pulls it down.
  assign dht_in = ~(host_low | dht_drive_low);

  always #5 clk = ~clk;

  dht11_emulator #(
    .CLKS_PER_US(1),
    .T_START_MIN_US(T_START)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dht_in(dht_in),
    .temperature(temperature),
    .humidity(humidity),
    .dht_drive_low(dht_drive_low),
    .busy(busy),
    .frame_done(frame_done)
  );

  // The 40 bits a DHT11 sends for given readings, first-sent bit at [39].
  function automatic logic [39:0] modelFrame(input int h, input int t);
    int sum;
    sum = (h + t) % 256;
    return {8'(h), 8'h00, 8'(t), 8'h00, 8'(sum)};
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Compare one finished frame (measured segments) against the oldest prediction.
  task automatic checkFrame();
    logic [39:0] exp_f;
    logic [39:0] got_f;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_frame: got frame_done, expected no frame");
      return;
    end
    exp_f = exp_q.pop_front();
    checkOutput("busy_at_done", busy, 0);
    checkOutput("wait_len", wait_len, T_WAIT);
    checkOutput("low_segments", mon_low_q.size(), 42);
    checkOutput("release_segments", mon_rel_q.size(), 41);
    if (mon_low_q.size() == 42 && mon_rel_q.size() == 41) begin
      checkOutput("resp_low", mon_low_q[0], T_RLOW);
      checkOutput("resp_high", mon_rel_q[0], T_RHIGH);
      got_f = '0;
      for (int i = 0; i < 40; i++) begin
        checkOutput($sformatf("bit_low[%0d]", i), mon_low_q[i+1], T_BLOW);
        checkOutput($sformatf("bit_high[%0d]", i), mon_rel_q[i+1], exp_f[39-i] ? T_ONE : T_ZERO);
        got_f = {got_f[38:0], (mon_rel_q[i+1] > 48) ? 1'b1 : 1'b0};
      end
      checkOutput("end_low", mon_low_q[41], T_BLOW);
      checkOutput("frame_bytes", got_f, exp_f);
    end
  endtask

  // Measures drive segments every cycle and checks each frame at frame_done.
  task automatic monitorLoop();
    logic prev_drive = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic in_frame = 1'b0;
    logic first_rise = 1'b0;
    int   t_edge = 0;
    int   t_busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        in_frame   = 1'b0;
        prev_drive = 1'b0;
        prev_busy  = 1'b0;
        prev_done  = 1'b0;
        mon_low_q.delete();
        mon_rel_q.delete();
      end else begin
        if (prev_done) checkOutput("frame_done_one_cycle", frame_done, 0);
        if (busy && !prev_busy) begin
          busy_rises++;
          in_frame   = 1'b1;
          first_rise = 1'b1;
          t_busy     = cyc;
          wait_len   = -1;
          mon_low_q.delete();
          mon_rel_q.delete();
        end
        if (dht_drive_low && !prev_drive) begin
          drive_rises++;
          if (in_frame) begin
            if (first_rise) wait_len = cyc - t_busy;
            else mon_rel_q.push_back(cyc - t_edge);
          end
          first_rise = 1'b0;
          t_edge     = cyc;
        end
        if (!dht_drive_low && prev_drive) begin
          if (in_frame) mon_low_q.push_back(cyc - t_edge);
          t_edge = cyc;
        end
        if (frame_done) begin
          checkFrame();
          in_frame = 1'b0;
        end
        prev_drive = dht_drive_low;
        prev_busy  = busy;
        prev_done  = frame_done;
      end
    end
  endtask

  // Host start request: pull the bus low for low_len cycles, then release.
  task automatic applyStimulus(input int low_len, input logic [7:0] h, input logic [7:0] t,
                               input bit expect_frame);
    @(negedge clk);
    humidity    = h;
    temperature = t;
    host_low    = 1'b1;
    repeat (low_len) @(negedge clk);
    host_low = 1'b0;
    if (expect_frame) exp_q.push_back(modelFrame(h, t));
  endtask

  task automatic waitFrameDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < FRAME_MAX && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic waitLevel(input string name, input logic want_busy, input logic want_drive,
                           input bit use_busy, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (use_busy ? (busy == want_busy) : (dht_drive_low == want_drive)) seen = 1'b1;
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic checkNoResponse(input int rises0, input int busy0);
    repeat (300) @(negedge clk);
    checkOutput("short_pulse_drive_rises", drive_rises, rises0);
    checkOutput("short_pulse_busy_rises", busy_rises, busy0);
    checkOutput("short_pulse_busy", busy, 0);
  endtask

  initial begin
    int r0;
    int b0;
    fork
      monitorLoop();
    join_none

    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_drive", dht_drive_low, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", frame_done, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] short host pulse");
    r0 = drive_rises;
    b0 = busy_rises;
    applyStimulus(60, 8'd60, 8'd25, 1'b0);
    checkNoResponse(r0, b0);

    $display("[TB] basic frames");
    applyStimulus(150, 8'd60, 8'd25, 1'b1);
    waitFrameDone("frame_60_25_done");
    applyStimulus(150, 8'd100, 8'd200, 1'b1);
    waitFrameDone("frame_100_200_done");

    $display("[TB] temperature change mid-frame");
    applyStimulus(150, 8'd60, 8'd25, 1'b1);
    waitLevel("busy_rise_tchange", 1'b1, 1'b0, 1'b1, 20);
    repeat (400) @(negedge clk);
    temperature = 8'd30;
    waitFrameDone("frame_tchange_done");
    applyStimulus(150, 8'd60, 8'd30, 1'b1);
    waitFrameDone("frame_60_30_done");

    $display("[TB] back-to-back with host glitch");
    applyStimulus(150, 8'd42, 8'd17, 1'b1);
    waitFrameDone("frame_b2b_first_done");
    applyStimulus(150, 8'd42, 8'd17, 1'b1);
    waitLevel("busy_rise_b2b", 1'b1, 1'b0, 1'b1, 20);
    repeat (250) @(negedge clk);
    waitLevel("glitch_drive_high", 1'b0, 1'b1, 1'b0, 200);
    waitLevel("glitch_drive_low", 1'b0, 1'b0, 1'b0, 200);
    host_low = 1'b1;
    repeat (20) @(negedge clk);
    host_low = 1'b0;
    waitFrameDone("frame_b2b_second_done");

    $display("[TB] reset mid-frame");
    applyStimulus(150, 8'd60, 8'd25, 1'b0);
    waitLevel("busy_rise_abort", 1'b1, 1'b0, 1'b1, 20);
    repeat (300) @(negedge clk);
    waitLevel("abort_drive_high", 1'b0, 1'b1, 1'b0, 200);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_drive_immediate", dht_drive_low, 0);
    checkOutput("abort_busy_immediate", busy, 0);
    checkOutput("abort_done_immediate", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_hold_drive", dht_drive_low, 0);
      checkOutput("abort_hold_busy", busy, 0);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(150, 8'd60, 8'd25, 1'b1);
    waitFrameDone("frame_after_reset_done");

    $display("[TB] random requests");
    for (int n = 0; n < 6; n++) begin
      logic [7:0] h;
      logic [7:0] t;
      h = 8'($urandom_range(0, 255));
      t = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        r0 = drive_rises;
        b0 = busy_rises;
        applyStimulus($urandom_range(5, 90), h, t, 1'b0);
        checkNoResponse(r0, b0);
      end else begin
        applyStimulus($urandom_range(120, 300), h, t, 1'b1);
        waitFrameDone("random_frame_done");
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
